// File: rtl/z80fi_pkg.sv
// z80fi_pkg: shared widths, register-snapshot field offsets and recorder states.
package z80fi_pkg;
  localparam int REGS_W  = 208;
  localparam int MAX_LEN = 4;
  // 16-bit fields packed from bit 0 upward: AF BC DE HL AF' BC' DE' HL' IX IY SP IP IR
  localparam int OFF_AF = 0, OFF_F = 0, OFF_A = 8, OFF_BC = 16, OFF_DE = 32, OFF_HL = 48;
  localparam int OFF_AF2 = 64, OFF_BC2 = 80, OFF_DE2 = 96, OFF_HL2 = 112;
  localparam int OFF_IX = 128, OFF_IY = 144, OFF_SP = 160, OFF_IP = 176, OFF_IR = 192;
  typedef enum logic {IDLE, CAPTURE} rec_state_e;
  function automatic logic [15:0] reg16(input logic [REGS_W-1:0] regs, input int off);
    return regs[off +: 16];
  endfunction
endpackage

// File: rtl/z80fi_bus_log.sv
// z80fi_bus_log: two-slot address/data logger; o_* show the slots with this cycle's strobe appended.
module z80fi_bus_log (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clr,
  input  logic        i_we,
  input  logic        i_valid,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  output logic        o_full,
  output logic        o_v1,
  output logic [15:0] o_a1,
  output logic [7:0]  o_d1,
  output logic        o_v2,
  output logic [15:0] o_a2,
  output logic [7:0]  o_d2
);
  logic [1:0]  r_cnt;
  logic [15:0] r_a1, r_a2;
  logic [7:0]  r_d1, r_d2;
  logic        w_put1, w_put2, w_new;
  assign o_full = r_cnt == 2'd2;
  assign w_put1 = i_valid && r_cnt == 2'd0;
  assign w_put2 = i_valid && r_cnt == 2'd1;
  assign w_new  = i_we && i_valid;
  assign o_v1 = r_cnt != 2'd0 || i_valid;
  assign o_a1 = w_put1 ? i_addr : r_a1;
  assign o_d1 = w_put1 ? i_data : r_d1;
  assign o_v2 = o_full || w_put2;
  assign o_a2 = w_put2 ? i_addr : r_a2;
  assign o_d2 = w_put2 ? i_data : r_d2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_a1  <= '0;
      r_d1  <= '0;
      r_a2  <= '0;
      r_d2  <= '0;
    end else if (i_clr) begin
      r_cnt <= {1'b0, w_new};
      r_a1  <= w_new ? i_addr : '0;
      r_d1  <= w_new ? i_data : '0;
      r_a2  <= '0;
      r_d2  <= '0;
    end else if (w_new && !o_full) begin
      r_cnt <= r_cnt + 2'd1;
      r_a1  <= o_a1;
      r_d1  <= o_d1;
      r_a2  <= o_a2;
      r_d2  <= o_d2;
    end
endmodule

// File: rtl/z80fi_insn_recorder.sv
// z80fi_insn_recorder: turns core trace strobes into one z80fi packet per retired instruction.
// Optional Z80FI_ORDER_EN adds the 64-bit retirement index output z80fi_order.
module z80fi_insn_recorder #(
  parameter int REGS_W  = z80fi_pkg::REGS_W,
  parameter int MAX_LEN = z80fi_pkg::MAX_LEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_insn_start,
  input  logic [REGS_W-1:0] core_regs_in,
  input  logic              core_fetch_valid,
  input  logic [7:0]        core_fetch_data,
  input  logic              core_rd_valid,
  input  logic [15:0]       core_rd_addr,
  input  logic [7:0]        core_rd_data,
  input  logic              core_wr_valid,
  input  logic [15:0]       core_wr_addr,
  input  logic [7:0]        core_wr_data,
  input  logic              core_retire,
  input  logic [REGS_W-1:0] core_regs_out,
  output logic              z80fi_valid,
  output logic [31:0]       z80fi_insn,
  output logic [2:0]        z80fi_insn_len,
  output logic [REGS_W-1:0] z80fi_regs_in,
  output logic [REGS_W-1:0] z80fi_regs_out,
  output logic              z80fi_mem_rd,
  output logic              z80fi_mem_rd2,
  output logic [15:0]       z80fi_bus_raddr,
  output logic [15:0]       z80fi_bus_raddr2,
  output logic [7:0]        z80fi_bus_rdata,
  output logic [7:0]        z80fi_bus_rdata2,
  output logic              z80fi_mem_wr,
  output logic              z80fi_mem_wr2,
  output logic [15:0]       z80fi_bus_waddr,
  output logic [15:0]       z80fi_bus_waddr2,
  output logic [7:0]        z80fi_bus_wdata,
  output logic [7:0]        z80fi_bus_wdata2,
  output logic              z80fi_error
`ifdef Z80FI_ORDER_EN
  ,
  output logic [63:0]       z80fi_order
`endif
);
  import z80fi_pkg::*;
  rec_state_e        r_state, w_state_n;
  logic [2:0]        r_len, w_len;
  logic [31:0]       r_insn, w_insn;
  logic [REGS_W-1:0] r_regs_in;
  logic              w_cap, w_retire, w_keep, w_we, w_fput, w_err;
  logic              w_rfull, w_rv1, w_rv2, w_wfull, w_wv1, w_wv2;
  logic [15:0]       w_ra1, w_ra2, w_wa1, w_wa2;
  logic [7:0]        w_rd1, w_rd2, w_wd1, w_wd2;
  assign w_cap    = r_state == CAPTURE;
  assign w_retire = w_cap && core_retire;
  // retire+start: this cycle's strobes close the old packet, the new capture opens empty
  assign w_keep   = core_insn_start && !w_retire;
  assign w_we     = w_keep || (w_cap && !core_insn_start);
  assign w_fput   = core_fetch_valid && r_len != 3'(MAX_LEN);
  assign w_len    = r_len + 3'(w_fput);
  assign w_insn   = r_insn | (w_fput ? 32'(core_fetch_data) << {r_len, 3'b000} : 32'd0);
  assign w_err    = (core_retire && !w_cap) || (w_cap && core_insn_start && !core_retire) ||
                    (w_retire && w_len == 3'd0) ||
                    (w_cap && !w_keep && ((core_fetch_valid && !w_fput) ||
                     (core_rd_valid && w_rfull) || (core_wr_valid && w_wfull)));
  always_comb begin
    w_state_n = r_state;
    w_state_n = core_insn_start ? CAPTURE : (w_retire ? IDLE : r_state);
  end
  z80fi_bus_log u_rd (
    .clk(clk), .reset_n(reset_n), .i_clr(core_insn_start), .i_we(w_we),
    .i_valid(core_rd_valid), .i_addr(core_rd_addr), .i_data(core_rd_data), .o_full(w_rfull),
    .o_v1(w_rv1), .o_a1(w_ra1), .o_d1(w_rd1), .o_v2(w_rv2), .o_a2(w_ra2), .o_d2(w_rd2)
  );
  z80fi_bus_log u_wr (
    .clk(clk), .reset_n(reset_n), .i_clr(core_insn_start), .i_we(w_we),
    .i_valid(core_wr_valid), .i_addr(core_wr_addr), .i_data(core_wr_data), .o_full(w_wfull),
    .o_v1(w_wv1), .o_a1(w_wa1), .o_d1(w_wd1), .o_v2(w_wv2), .o_a2(w_wa2), .o_d2(w_wd2)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_insn    <= '0;
      r_regs_in <= '0;
    end else begin
      r_state <= w_state_n;
      if (core_insn_start) begin
        r_len     <= (w_keep && core_fetch_valid) ? 3'd1 : 3'd0;
        r_insn    <= (w_keep && core_fetch_valid) ? 32'(core_fetch_data) : 32'd0;
        r_regs_in <= core_regs_in;
      end else if (w_cap) begin
        r_len  <= w_len;
        r_insn <= w_insn;
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      z80fi_valid      <= 1'b0;
      z80fi_insn       <= '0;
      z80fi_insn_len   <= '0;
      z80fi_regs_in    <= '0;
      z80fi_regs_out   <= '0;
      z80fi_mem_rd     <= 1'b0;
      z80fi_mem_rd2    <= 1'b0;
      z80fi_bus_raddr  <= '0;
      z80fi_bus_raddr2 <= '0;
      z80fi_bus_rdata  <= '0;
      z80fi_bus_rdata2 <= '0;
      z80fi_mem_wr     <= 1'b0;
      z80fi_mem_wr2    <= 1'b0;
      z80fi_bus_waddr  <= '0;
      z80fi_bus_waddr2 <= '0;
      z80fi_bus_wdata  <= '0;
      z80fi_bus_wdata2 <= '0;
      z80fi_error      <= 1'b0;
    end else begin
      z80fi_valid <= w_retire;
      z80fi_error <= z80fi_error | w_err;
      if (w_retire) begin
        z80fi_insn       <= w_insn;
        z80fi_insn_len   <= w_len;
        z80fi_regs_in    <= r_regs_in;
        z80fi_regs_out   <= core_regs_out;
        z80fi_mem_rd     <= w_rv1;
        z80fi_mem_rd2    <= w_rv2;
        z80fi_bus_raddr  <= w_ra1;
        z80fi_bus_raddr2 <= w_ra2;
        z80fi_bus_rdata  <= w_rd1;
        z80fi_bus_rdata2 <= w_rd2;
        z80fi_mem_wr     <= w_wv1;
        z80fi_mem_wr2    <= w_wv2;
        z80fi_bus_waddr  <= w_wa1;
        z80fi_bus_waddr2 <= w_wa2;
        z80fi_bus_wdata  <= w_wd1;
        z80fi_bus_wdata2 <= w_wd2;
      end
    end
`ifdef Z80FI_ORDER_EN
  logic [63:0] r_retired;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_retired   <= '0;
      z80fi_order <= '0;
    end else if (w_retire) begin
      r_retired   <= r_retired + 64'd1;
      z80fi_order <= r_retired;
    end
`endif
endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// tb_z80fi_insn_recorder: directed stimulus against an instruction-level packet model.
module tb_z80fi_insn_recorder;
  import z80fi_pkg::*;
  localparam int NEVER = 32'h7fffffff;
  logic              clk = 1'b0, reset_n = 1'b0;
  logic              core_insn_start = 0, core_fetch_valid = 0, core_rd_valid = 0;
  logic              core_wr_valid = 0, core_retire = 0;
  logic [REGS_W-1:0] core_regs_in = '0, core_regs_out = '0;
  logic [7:0]        core_fetch_data = '0, core_rd_data = '0, core_wr_data = '0;
  logic [15:0]       core_rd_addr = '0, core_wr_addr = '0;
  logic              z80fi_valid, z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr, z80fi_mem_wr2;
  logic              z80fi_error;
  logic [31:0]       z80fi_insn;
  logic [2:0]        z80fi_insn_len;
  logic [REGS_W-1:0] z80fi_regs_in, z80fi_regs_out;
  logic [15:0]       z80fi_bus_raddr, z80fi_bus_raddr2, z80fi_bus_waddr, z80fi_bus_waddr2;
  logic [7:0]        z80fi_bus_rdata, z80fi_bus_rdata2, z80fi_bus_wdata, z80fi_bus_wdata2;
`ifdef Z80FI_ORDER_EN
  logic [63:0]       z80fi_order;
`endif
  always #5 clk = ~clk;
  z80fi_insn_recorder dut (
    .clk(clk), .reset_n(reset_n), .core_insn_start(core_insn_start), .core_regs_in(core_regs_in),
    .core_fetch_valid(core_fetch_valid), .core_fetch_data(core_fetch_data),
    .core_rd_valid(core_rd_valid), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_retire(core_retire), .core_regs_out(core_regs_out),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_regs_in(z80fi_regs_in), .z80fi_regs_out(z80fi_regs_out),
    .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_rd2(z80fi_mem_rd2),
    .z80fi_bus_raddr(z80fi_bus_raddr), .z80fi_bus_raddr2(z80fi_bus_raddr2),
    .z80fi_bus_rdata(z80fi_bus_rdata), .z80fi_bus_rdata2(z80fi_bus_rdata2),
    .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_wr2(z80fi_mem_wr2),
    .z80fi_bus_waddr(z80fi_bus_waddr), .z80fi_bus_waddr2(z80fi_bus_waddr2),
    .z80fi_bus_wdata(z80fi_bus_wdata), .z80fi_bus_wdata2(z80fi_bus_wdata2),
    .z80fi_error(z80fi_error)
`ifdef Z80FI_ORDER_EN
    , .z80fi_order(z80fi_order)
`endif
  );
  typedef struct {
    int                due;
    logic [31:0]       insn;
    logic [2:0]        len;
    logic [REGS_W-1:0] ri, ro;
    logic              rd, rd2, wr, wr2;
    logic [15:0]       ra, ra2, wa, wa2;
    logic [7:0]        rdt, rdt2, wdt, wdt2;
    logic [63:0]       order;
  } pkt_t;
  pkt_t              exp_q[$];
  logic [7:0]        m_bytes[$];
  logic [23:0]       m_rd[$], m_wr[$];
  bit                m_active = 0;
  logic [REGS_W-1:0] m_ri = '0;
  logic [63:0]       m_order = '0;
  int                edge_n = 0, err_due = NEVER, checks = 0, errors = 0;
  always @(posedge clk) edge_n++;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask
  always @(negedge clk) if (reset_n) begin
    bit due;
    pkt_t p;
    due = exp_q.size() > 0 && exp_q[0].due == edge_n;
    chk("valid", z80fi_valid, due);
    chk("error", z80fi_error, edge_n >= err_due);
    if (due) begin
      p = exp_q.pop_front();
      chk("insn", z80fi_insn, p.insn);
      chk("len", z80fi_insn_len, p.len);
      chk("regs_in", z80fi_regs_in, p.ri);
      chk("regs_out", z80fi_regs_out, p.ro);
      chk("rd", {z80fi_mem_rd, z80fi_mem_rd2}, {p.rd, p.rd2});
      chk("rslots", {z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_raddr2, z80fi_bus_rdata2},
          {p.ra, p.rdt, p.ra2, p.rdt2});
      chk("wr", {z80fi_mem_wr, z80fi_mem_wr2}, {p.wr, p.wr2});
      chk("wslots", {z80fi_bus_waddr, z80fi_bus_wdata, z80fi_bus_waddr2, z80fi_bus_wdata2},
          {p.wa, p.wdt, p.wa2, p.wdt2});
`ifdef Z80FI_ORDER_EN
      chk("order", z80fi_order, p.order);
`endif
    end
  end
  function automatic logic [REGS_W-1:0] rnd_regs();
    logic [REGS_W-1:0] r;
    for (int i = 0; i < 13; i++) r[16*i +: 16] = 16'($urandom);
    return r;
  endfunction
  function automatic logic [REGS_W-1:0] set16(input logic [REGS_W-1:0] r, input int off,
                                               input logic [15:0] v);
    r[off +: 16] = v;
    return r;
  endfunction
  // Strobes beyond capacity are dropped and flag an error.
  task automatic add_strobes(inout bit err);
    if (core_fetch_valid) begin
      if (m_bytes.size() >= MAX_LEN) err = 1; else m_bytes.push_back(core_fetch_data);
    end
    if (core_rd_valid) begin
      if (m_rd.size() >= 2) err = 1; else m_rd.push_back({core_rd_addr, core_rd_data});
    end
    if (core_wr_valid) begin
      if (m_wr.size() >= 2) err = 1; else m_wr.push_back({core_wr_addr, core_wr_data});
    end
  endtask
  function automatic pkt_t build();
    pkt_t p;
    p = '{default: '0};
    p.len = 3'(m_bytes.size());
    foreach (m_bytes[i]) p.insn[8*i +: 8] = m_bytes[i];
    p.ri = m_ri;
    p.ro = core_regs_out;
    p.order = m_order;
    if (m_rd.size() > 0) begin p.rd = 1; {p.ra, p.rdt} = m_rd[0]; end
    if (m_rd.size() > 1) begin p.rd2 = 1; {p.ra2, p.rdt2} = m_rd[1]; end
    if (m_wr.size() > 0) begin p.wr = 1; {p.wa, p.wdt} = m_wr[0]; end
    if (m_wr.size() > 1) begin p.wr2 = 1; {p.wa2, p.wdt2} = m_wr[1]; end
    return p;
  endfunction
  task automatic open_insn();
    m_bytes.delete();
    m_rd.delete();
    m_wr.delete();
    m_ri = core_regs_in;
  endtask
  task automatic tick();
    bit emit = 0, err = 0;
    pkt_t p;
    if (m_active && core_retire) begin
      add_strobes(err);
      p = build();
      emit = 1;
      m_order++;
      if (m_bytes.size() == 0) err = 1;
      m_active = core_insn_start;
      if (core_insn_start) open_insn();
    end else begin
      if (core_retire) err = 1;
      if (core_insn_start) begin
        if (m_active) err = 1;
        open_insn();
        m_active = 1;
      end
      if (m_active) add_strobes(err);
    end
    @(posedge clk);
    #1;
    if (emit) begin p.due = edge_n; exp_q.push_back(p); end
    if (err && err_due == NEVER) err_due = edge_n;
    {core_insn_start, core_retire, core_fetch_valid, core_rd_valid, core_wr_valid} = '0;
  endtask
  task automatic fe(input logic [7:0] d); core_fetch_valid = 1; core_fetch_data = d; endtask
  task automatic rdm(input logic [15:0] a, input logic [7:0] d);
    core_rd_valid = 1; core_rd_addr = a; core_rd_data = d;
  endtask
  task automatic wrm(input logic [15:0] a, input logic [7:0] d);
    core_wr_valid = 1; core_wr_addr = a; core_wr_data = d;
  endtask
  task automatic start(input logic [REGS_W-1:0] r); core_insn_start = 1; core_regs_in = r; endtask
  task automatic retire(input logic [REGS_W-1:0] r); core_retire = 1; core_regs_out = r; endtask
  task automatic do_reset();
    reset_n = 0;
    {core_insn_start, core_retire, core_fetch_valid, core_rd_valid, core_wr_valid} = '0;
    exp_q.delete();
    m_active = 0;
    m_order = '0;
    err_due = NEVER;
    @(negedge clk);
    chk("rst_valid", z80fi_valid, 0);
    chk("rst_error", z80fi_error, 0);
    chk("rst_insn", {z80fi_insn, z80fi_insn_len}, 0);
    chk("rst_regs", z80fi_regs_out, 0);
    chk("rst_mem", {z80fi_mem_rd, z80fi_mem_wr, z80fi_bus_raddr, z80fi_bus_waddr}, 0);
    #2 reset_n = 1;
    @(posedge clk);
    #1;
  endtask
  logic [REGS_W-1:0] ri, ro, ri2;
  initial begin
    do_reset();
    // RET NZ taken: pops 1234h from 1000h
    ri = set16(rnd_regs(), OFF_SP, 16'h1000);
    ro = set16(set16(ri, OFF_IP, 16'h1234), OFF_SP, 16'h1002);
    start(ri); fe(8'hC0); tick();
    rdm(16'h1000, 8'h34); tick();
    rdm(16'h1001, 8'h12); tick();
    retire(ro); tick();
    @(negedge clk);
    chk("ret_insn", {z80fi_insn, z80fi_insn_len}, {32'h000000C0, 3'd1});
    chk("ret_rd", {z80fi_mem_rd, z80fi_bus_raddr, z80fi_bus_rdata, z80fi_mem_rd2,
                   z80fi_bus_raddr2, z80fi_bus_rdata2}, {1'b1, 16'h1000, 8'h34, 1'b1, 16'h1001, 8'h12});
    chk("ret_ip", reg16(z80fi_regs_out, OFF_IP), 16'h1234);
    tick();
    // LD (IX+5),7
    ri = set16(rnd_regs(), OFF_IX, 16'h2000);
    start(ri); fe(8'hDD); tick();
    fe(8'h36); tick();
    fe(8'h05); tick();
    fe(8'h07); wrm(16'h2005, 8'h07); tick();
    retire(rnd_regs()); tick();
    @(negedge clk);
    chk("ld_insn", {z80fi_insn, z80fi_insn_len}, {32'h070536DD, 3'd4});
    chk("ld_wr", {z80fi_mem_wr, z80fi_bus_waddr, z80fi_bus_wdata, z80fi_mem_wr2},
        {1'b1, 16'h2005, 8'h07, 1'b0});
    tick();
    // back-to-back NOP then INC A
    ri = rnd_regs(); ri2 = rnd_regs();
    start(ri); fe(8'h00); tick();
    retire(ri2); start(ri2); tick();
    @(negedge clk);
    chk("b2b_first", {z80fi_valid, z80fi_insn, z80fi_insn_len}, {1'b1, 32'h0, 3'd1});
    fe(8'h3C); retire(rnd_regs()); tick();
    @(negedge clk);
    chk("b2b_second", {z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_regs_in},
        {1'b1, 32'h3C, 3'd1, ri2});
    tick();
    @(negedge clk);
    chk("hold", {z80fi_valid, z80fi_insn}, {1'b0, 32'h3C});
    // reset mid-capture, then RET
    start(rnd_regs()); fe(8'h11); tick();
    fe(8'h22); tick();
    do_reset();
    start(rnd_regs()); fe(8'hC9); tick();
    retire(rnd_regs()); tick();
    @(negedge clk);
    chk("post_rst", {z80fi_valid, z80fi_insn, z80fi_insn_len}, {1'b1, 32'hC9, 3'd1});
`ifdef Z80FI_ORDER_EN
    chk("post_rst_order", z80fi_order, 64'd0);
`endif
    tick();
    // overflow: five bytes and three reads
    start(rnd_regs()); fe(8'h01); tick();
    fe(8'h02); tick();
    fe(8'h03); rdm(16'h0100, 8'hA1); tick();
    fe(8'h04); rdm(16'h0101, 8'hA2); tick();
    fe(8'h05); rdm(16'h0102, 8'hA3); tick();
    retire(rnd_regs()); tick();
    @(negedge clk);
    chk("ovf_pkt", {z80fi_insn, z80fi_insn_len, z80fi_error}, {32'h04030201, 3'd4, 1'b1});
    repeat (3) tick();
    // retire while idle
    do_reset();
    retire(rnd_regs()); tick();
    @(negedge clk);
    chk("idle_retire", {z80fi_valid, z80fi_error}, 2'b01);
    // abandoned instruction and zero-length retire
    start(rnd_regs()); fe(8'h11); tick();
    start(rnd_regs()); fe(8'h22); tick();
    retire(rnd_regs()); tick();
    @(negedge clk);
    chk("abandon", {z80fi_insn, z80fi_insn_len}, {32'h22, 3'd1});
    start(rnd_regs()); tick();
    retire(rnd_regs()); tick();
    @(negedge clk);
    chk("zero_len", {z80fi_valid, z80fi_insn_len}, {1'b1, 3'd0});
    repeat (3) tick();
    chk("drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/z80fi_insn_recorder.md
Name: z80fi_insn_recorder

Overview:
Upstream producer of the z80fi packet that every insn_spec module and the formal checker consume.
- Watches the core's per-instruction trace strobes: start, byte fetch, memory read/write, retire.
- Accumulates one instruction's opcode bytes, register snapshots and up to two memory reads and two memory writes.
- Emits exactly one single-cycle z80fi packet per retired instruction.
- Flags protocol violations.

Parameters:
- REGS_W, 208: width of the packed register snapshot (AF BC DE HL AF' BC' DE' HL' IX IY SP IP IR; 13×16).
- MAX_LEN, 4: maximum instruction bytes captured; must be ≤ 4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- core_insn_start  in  1  first cycle of an instruction's M1; samples core_regs_in.
- core_regs_in  in  REGS_W  architectural state before the instruction.
- core_fetch_valid  in  1  one opcode/operand byte fetched this cycle.
- core_fetch_data  in  8  fetched byte.
- core_rd_valid  in  1  data memory read completes.
- core_rd_addr  in  16  read address.
- core_rd_data  in  8  read data.
- core_wr_valid  in  1  data memory write.
- core_wr_addr  in  16  write address.
- core_wr_data  in  8  write data.
- core_retire  in  1  instruction complete; core_regs_out valid.
- core_regs_out  in  REGS_W  architectural state after the instruction.
- z80fi_valid  out  1  packet valid, one-cycle pulse.
- z80fi_insn  out  32  bytes in fetch order; first byte in [7:0]; unused bytes 0.
- z80fi_insn_len  out  3  bytes fetched, 1..4.
- z80fi_regs_in / z80fi_regs_out  out  REGS_W  register snapshots.
- z80fi_mem_rd, z80fi_mem_rd2  out  1  first/second read occurred.
- z80fi_bus_raddr, z80fi_bus_raddr2  out  16; z80fi_bus_rdata, z80fi_bus_rdata2  out  8.
- z80fi_mem_wr, z80fi_mem_wr2  out  1; z80fi_bus_waddr, z80fi_bus_waddr2  out  16; z80fi_bus_wdata, z80fi_bus_wdata2  out  8.
- z80fi_error  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: all outputs 0; state IDLE; all capture registers cleared. Reset mid-capture discards the partial instruction; no packet is emitted.
- States:
  - IDLE: core_insn_start → CAPTURE; regs_in latched; counters cleared.
  - CAPTURE: accumulate strobes; core_retire → emit packet, then IDLE.
- Capture:
  - Fetch/read/write strobes are sampled in the start cycle and every CAPTURE cycle, including the retire cycle.
  - A strobe in the retire cycle is included in that packet.
- Fetch: byte stored at index len; len increments. A fetch when len == MAX_LEN sets z80fi_error; the byte is dropped.
- Reads: first read → slot 1, second → slot 2. A third read sets error and is dropped. Writes behave identically.
- Packet:
  - Registered; z80fi_valid is high the cycle after core_retire, for exactly one cycle.
  - All packet fields hold their values until the next packet.
- Back-to-back: core_retire and core_insn_start in the same cycle close the current packet and open a new capture. No bubble is required.
- Errors:
  - core_retire in IDLE: error set, no packet.
  - core_insn_start in CAPTURE without retire: error set, capture restarts, no packet for the abandoned instruction.
  - Retire with len == 0: error set, packet still emitted with insn_len 0.
- z80fi_error is cleared only by reset.

Optional Feature:
- Macro Z80FI_ORDER_EN.
- Defined: adds output z80fi_order (64 bits).
  - Retirement index, 0 for the first packet after reset.
  - Increments by 1 per emitted packet and wraps at 2^64.
  - Valid alongside z80fi_valid.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package z80fi_pkg:
  - REGS_W constant.
  - Register field offsets within the snapshot (SP, IP, F, ...).
  - Recorder state enum {IDLE, CAPTURE}.
- Sub-module z80fi_bus_log: a two-slot address/data logger with overflow flag.
  - Instantiated twice, once for reads and once for writes.

Test Plan:
- RET NZ, condition met: start with SP=1000h; fetch C0h; read 1000h→34h; read 1001h→12h; retire with regs_out IP=1234h, SP=1002h → one packet: insn_len=1, insn=000000C0h, mem_rd=mem_rd2=1, raddr=1000h, rdata=34h, raddr2=1001h, rdata2=12h, regs_out IP=1234h.
- LD (IX+5),7: fetch DD,36,05,07; write 2005h←07h; retire → insn_len=4, insn=070536DDh, mem_wr=1, waddr=2005h, wdata=07h, mem_wr2=0.
- Back-to-back: retire and start asserted in the same cycle for instructions 00h then 3Ch → two packets on consecutive cycles, each insn_len=1, with correct regs_in/regs_out.
- Fifth fetch byte, or third read, before retire → z80fi_error=1 and stays 1; packet insn_len=4.
- Reset asserted mid-capture after two fetch bytes, then deasserted; next instruction C9h → no stale packet; next packet insn_len=1, insn=000000C9h; with Z80FI_ORDER_EN, order=0.
- Retire while IDLE → error=1, z80fi_valid stays 0.
